// File: rtl/regfile_sb.sv
// Two-read / one-write register file with same-cycle write bypass and a
// busy-bit scoreboard that tracks registers with a writer still in flight.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WriteReg,
    input  logic [AW-1:0]    WriteAddr,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             Reserve,
    input  logic [AW-1:0]    ResAddr,
    input  logic [AW-1:0]    SrcAddr1,
    input  logic [AW-1:0]    SrcAddr2,
    output logic [WIDTH-1:0] SrcData1,
    output logic [WIDTH-1:0] SrcData2,
    output logic             SrcRdy1,
    output logic             SrcRdy2,
    output logic             ResConflict
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] wr_dec;
    logic [DEPTH-1:0] res_dec;

    logic             wr_en;
    logic             res_en;
    logic [AW-1:0]    src_addr [2];
    logic [WIDTH-1:0] src_data [2];
    logic             src_rdy  [2];

    // Reset masks both request strobes so nothing in flight survives it.
    assign wr_en  = WriteReg && !rst;
    assign res_en = Reserve && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam bit WRITABLE = (ZERO_REG == 0) || (gi != 0);

            assign wr_dec[gi]  = WRITABLE && wr_en  && (WriteAddr == AW'(gi));
            assign res_dec[gi] = WRITABLE && res_en && (ResAddr   == AW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else if (wr_dec[gi]) begin
                    regs_q[gi] <= WriteData;
                end
            end
        end
    endgenerate

    // A reservation issued as the older writer retires wins: the reg stays busy.
    always_comb begin
        busy_d = (busy_q & ~wr_dec) | res_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign src_addr[0] = SrcAddr1;
    assign src_addr[1] = SrcAddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                src_data[gi] = regs_q[src_addr[gi]];
                src_rdy[gi]  = !busy_q[src_addr[gi]];
                if (wr_en && (WriteAddr == src_addr[gi])) begin
                    src_data[gi] = WriteData;
                    src_rdy[gi]  = 1'b1;
                end
                if ((ZERO_REG != 0) && (src_addr[gi] == '0)) begin
                    src_data[gi] = '0;
                    src_rdy[gi]  = 1'b1;
                end
            end
        end
    endgenerate

    assign SrcData1 = src_data[0];
    assign SrcData2 = src_data[1];
    assign SrcRdy1  = src_rdy[0];
    assign SrcRdy2  = src_rdy[1];

    always_comb begin
        ResConflict = res_en && busy_q[ResAddr] && !(wr_en && (WriteAddr == ResAddr));
        if ((ZERO_REG != 0) && (ResAddr == '0)) begin
            ResConflict = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default instance plus a 32x8 instance
// without a zero register. Expectations are queued, a negedge monitor checks.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_wr, a_res, a_r1, a_r2, a_cf;
    logic [3:0]  a_waddr, a_raddr, a_s1, a_s2;
    logic [15:0] a_wdata, a_d1, a_d2;

    logic        b_wr, b_res, b_r1, b_r2, b_cf;
    logic [2:0]  b_waddr, b_raddr, b_s1, b_s2;
    logic [31:0] b_wdata, b_d1, b_d2;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .WriteReg(a_wr), .WriteAddr(a_waddr), .WriteData(a_wdata),
        .Reserve(a_res), .ResAddr(a_raddr),
        .SrcAddr1(a_s1), .SrcAddr2(a_s2),
        .SrcData1(a_d1), .SrcData2(a_d2),
        .SrcRdy1(a_r1), .SrcRdy2(a_r2), .ResConflict(a_cf)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(8), .ZERO_REG(0)) u_sweep (
        .clk(clk), .rst(rst),
        .WriteReg(b_wr), .WriteAddr(b_waddr), .WriteData(b_wdata),
        .Reserve(b_res), .ResAddr(b_raddr),
        .SrcAddr1(b_s1), .SrcAddr2(b_s2),
        .SrcData1(b_d1), .SrcData2(b_d2),
        .SrcRdy1(b_r1), .SrcRdy2(b_r2), .ResConflict(b_cf)
    );

    // Signal codes: 0..4 = main D1,D2,R1,R2,CF ; 5..9 = same on sweep instance
    localparam int D1 = 0, D2 = 1, R1 = 2, R2 = 3, CF = 4, SW = 5;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void expect_v(int sig, logic [31:0] val, string name);
        exp_t e;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endfunction

    function automatic logic [31:0] sample(int sig);
        case (sig)
            0:       return {16'h0, a_d1};
            1:       return {16'h0, a_d2};
            2:       return {31'h0, a_r1};
            3:       return {31'h0, a_r2};
            4:       return {31'h0, a_cf};
            5:       return b_d1;
            6:       return b_d2;
            7:       return {31'h0, b_r1};
            8:       return {31'h0, b_r2};
            9:       return {31'h0, b_cf};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = sample(mon_e.sig);
            n_checks++;
            if (mon_act !== mon_e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", mon_e.name, mon_act, mon_e.val);
            end else begin
                $display("ok   %s: %h", mon_e.name, mon_act);
            end
        end
    end

    // Advance one cycle and drop all strobes; the caller then sets this cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        a_wr  = 1'b0;
        a_res = 1'b0;
        b_wr  = 1'b0;
        b_res = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_wr = 0; a_res = 0; a_waddr = 0; a_wdata = 0; a_raddr = 0; a_s1 = 0; a_s2 = 0;
        b_wr = 0; b_res = 0; b_waddr = 0; b_wdata = 0; b_raddr = 0; b_s1 = 0; b_s2 = 0;
        step();
        step();

        // Reset state
        step(); rst = 1'b0; a_s1 = 5; a_s2 = 6;
        expect_v(D1, 0, "rst_d1"); expect_v(R1, 1, "rst_r1");
        expect_v(D2, 0, "rst_d2"); expect_v(R2, 1, "rst_r2"); expect_v(CF, 0, "rst_cf");

        // Write r5, reserve r6, then reset mid-operation
        step(); a_wr = 1; a_waddr = 5; a_wdata = 16'hBEEF; a_res = 1; a_raddr = 6;
        expect_v(D1, 16'hBEEF, "r5_bypass");
        step();
        expect_v(D1, 16'hBEEF, "r5_stored"); expect_v(R2, 0, "r6_busy");
        step(); rst = 1'b1;
        step(); rst = 1'b0; a_res = 1; a_raddr = 6;
        expect_v(D1, 0, "post_rst_d1"); expect_v(R1, 1, "post_rst_r1");
        expect_v(R2, 1, "post_rst_r6_rdy"); expect_v(CF, 0, "post_rst_cf");

        // Release r6, then write/read and bypass
        step(); a_wr = 1; a_waddr = 6; a_wdata = 16'h0055; a_s1 = 6;
        expect_v(D1, 16'h0055, "r6_bypass"); expect_v(R1, 1, "r6_bypass_rdy");
        step(); a_wr = 1; a_waddr = 3; a_wdata = 16'h1234; a_s1 = 3; a_s2 = 6;
        expect_v(D1, 16'h1234, "r3_bypass"); expect_v(R1, 1, "r3_bypass_rdy");
        expect_v(D2, 16'h0055, "r6_stored"); expect_v(R2, 1, "r6_released");
        step(); a_s1 = 6; a_s2 = 3;
        expect_v(D2, 16'h1234, "r3_stored"); expect_v(R2, 1, "r3_rdy");
        expect_v(D1, 16'h0055, "r6_kept");

        // Zero register
        step(); a_wr = 1; a_waddr = 0; a_wdata = 16'hFFFF; a_s1 = 0;
        expect_v(D1, 0, "r0_wr_d1"); expect_v(R1, 1, "r0_wr_r1");
        step(); a_res = 1; a_raddr = 0;
        expect_v(D1, 0, "r0_res_d1"); expect_v(R1, 1, "r0_res_r1"); expect_v(CF, 0, "r0_res_cf");
        step(); a_res = 1; a_raddr = 0;
        expect_v(D1, 0, "r0_res2_d1"); expect_v(R1, 1, "r0_res2_r1"); expect_v(CF, 0, "r0_res2_cf");

        // Scoreboard life cycle on r7
        step(); a_res = 1; a_raddr = 7; a_s1 = 7;
        expect_v(R1, 1, "r7_N_rdy"); expect_v(CF, 0, "r7_N_cf");
        step();
        expect_v(R1, 0, "r7_N1_rdy");
        step();
        expect_v(R1, 0, "r7_N2_rdy");
        step(); a_wr = 1; a_waddr = 7; a_wdata = 16'h00AA;
        expect_v(R1, 1, "r7_N3_rdy"); expect_v(D1, 16'h00AA, "r7_N3_d1");
        step();
        expect_v(R1, 1, "r7_N4_rdy"); expect_v(D1, 16'h00AA, "r7_N4_d1");
        step();
        expect_v(R1, 1, "r7_N5_rdy");

        // Simultaneous reserve + write, then conflict on r9
        step(); a_res = 1; a_raddr = 9; a_s1 = 9;
        expect_v(CF, 0, "r9_first_res_cf");
        step(); a_res = 1; a_raddr = 9; a_wr = 1; a_waddr = 9; a_wdata = 16'h0F0F;
        expect_v(CF, 0, "r9_res_wr_cf"); expect_v(D1, 16'h0F0F, "r9_res_wr_d1");
        step();
        expect_v(D1, 16'h0F0F, "r9_after_d1"); expect_v(R1, 0, "r9_after_busy");
        step(); a_res = 1; a_raddr = 9;
        expect_v(CF, 1, "r9_conflict"); expect_v(R1, 0, "r9_conflict_rdy");
        step(); a_s2 = 5;
        expect_v(R1, 0, "r9_still_busy"); expect_v(D2, 0, "r5_cleared");

        // Parameter sweep: WIDTH=32, DEPTH=8, ZERO_REG=0
        step(); b_wr = 1; b_waddr = 0; b_wdata = 32'hDEADBEEF; b_s1 = 0;
        expect_v(SW + D1, 32'hDEADBEEF, "sw_r0_bypass");
        step();
        expect_v(SW + D1, 32'hDEADBEEF, "sw_r0_stored"); expect_v(SW + R1, 1, "sw_r0_rdy");
        step(); b_res = 1; b_raddr = 0;
        expect_v(SW + R1, 1, "sw_r0_res_same"); expect_v(SW + CF, 0, "sw_r0_res_cf");
        step(); b_res = 1; b_raddr = 0;
        expect_v(SW + R1, 0, "sw_r0_busy"); expect_v(SW + CF, 1, "sw_r0_conflict");
        step(); b_wr = 1; b_waddr = 7; b_wdata = 32'hCAFEF00D; b_s2 = 7;
        expect_v(SW + D2, 32'hCAFEF00D, "sw_r7_bypass");
        for (int i = 0; i < 7; i++) begin
            step(); b_s1 = 3'(i);
            expect_v(SW + D1, (i == 0) ? 32'hDEADBEEF : 32'h0, $sformatf("sw_alias_r%0d", i));
            expect_v(SW + D2, 32'hCAFEF00D, $sformatf("sw_r7_held_%0d", i));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a configurable number of entries and a configurable data width. It has two read ports and one write port, with write-before-read bypass on both read ports. A busy-bit scoreboard tracks which registers have a write still pending in the pipeline. It sits between decode and writeback: decode reads operands and reserves its destination register, and writeback commits the result and releases the reservation.

## Interface
- WIDTH, 16, data bits per register
- DEPTH, 16, number of registers (power of two, at least 2)
- AW, $clog2(DEPTH), address width (derived; do not override)
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and never becomes busy

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- WriteReg  input  1  commit WriteData to WriteAddr this cycle
- WriteAddr  input  AW  write destination
- WriteData  input  WIDTH  write data
- Reserve  input  1  mark ResAddr busy (decode has issued a writer)
- ResAddr  input  AW  register to reserve
- SrcAddr1  input  AW  read port 1 address
- SrcAddr2  input  AW  read port 2 address
- SrcData1  output  WIDTH  read port 1 data (combinational)
- SrcData2  output  WIDTH  read port 2 data (combinational)
- SrcRdy1  output  1  read port 1 operand is not busy
- SrcRdy2  output  1  read port 2 operand is not busy
- ResConflict  output  1  Reserve targets a register that is already busy and is not being written this cycle

## Operation
- **Storage.** DEPTH x WIDTH flops `regs` and DEPTH busy flops `busy`.
- **Write.** If WriteReg is high and the address is writable, `regs[WriteAddr] <= WriteData` at the edge. When ZERO_REG=1, address 0 is not writable.
- **Read.** `SrcDataN = regs[SrcAddrN]`, with these overrides:
  - If ZERO_REG=1 and SrcAddrN==0, the output is 0.
  - Otherwise, if WriteReg is high and WriteAddr==SrcAddrN, the output is WriteData (bypass).
- **Ready.** `SrcRdyN = !busy[SrcAddrN]`, with these overrides:
  - If WriteReg is high and WriteAddr==SrcAddrN, SrcRdyN is forced to 1 (bypassed value is valid).
  - If ZERO_REG=1 and SrcAddrN==0, SrcRdyN is always 1.
  - Reserve in the same cycle does not affect SrcRdyN.
- **Scoreboard update** at each edge:
  - If WriteReg is high, clear `busy[WriteAddr]`.
  - Then, if Reserve is high, set `busy[ResAddr]`.
  - Set beats clear: with Reserve and WriteReg to the same address, the register ends busy. This models a newer writer being issued as an older one retires.
  - Reserve of register 0 with ZERO_REG=1 has no effect.
- **ResConflict** is `Reserve && busy[ResAddr] && !(WriteReg && WriteAddr==ResAddr)`. It is informational only: the reservation still takes effect and the register stays busy.
  - Forced 0 for register 0 when ZERO_REG=1.
- **Reset.** While rst is high:
  - All `regs` and `busy` flops clear to 0.
  - WriteReg and Reserve are ignored.
  - Outputs reflect the pre-edge state until the first edge with rst high; after that, SrcDataN=0, SrcRdyN=1 and ResConflict=0.
- **Reset mid-operation.** Pending reservations are discarded, with no error indication.

## Timing
- Read latency is 0 cycles: SrcData, SrcRdy and ResConflict are combinational from the addresses and current state.
- Write latency is 1 edge into storage. The bypass makes the written value visible on the read ports in the same cycle.
- A Reserve becomes visible on SrcRdy in the cycle after it is presented.
- The critical path runs SrcAddr -> DEPTH:1 mux -> bypass mux; there is no registered output.
- Each port has one operation per cycle, so there are no structural hazards.

## Test plan
- **Reset.** Write 0xBEEF to r5, then pulse rst for one cycle.
  - Required: SrcData1(r5)=0x0000, SrcRdy1=1, ResConflict=0.
- **Write/read and bypass.** In cycle N, WriteReg r3=0x1234 with SrcAddr1=3.
  - Required: SrcData1=0x1234 in cycle N.
  - Required: with no write in cycle N+1, SrcData2(r3)=0x1234.
- **Zero register.** WriteReg r0=0xFFFF, then Reserve r0.
  - Required: SrcData1(r0)=0, SrcRdy1=1, ResConflict=0 in all cycles.
- **Scoreboard life cycle.** Reserve r7 in cycle N; WriteReg r7=0x00AA in cycle N+3.
  - Required: SrcRdy1(r7)=0 in cycles N+1 and N+2.
  - Required: SrcRdy1(r7)=1 with SrcData1=0x00AA in cycle N+3.
  - Required: SrcRdy1(r7)=1 from cycle N+4 onward.
- **Simultaneous events and conflict.**
  - With r9 busy, Reserve r9 together with WriteReg r9=0x0F0F. Required: ResConflict=0 and r9 busy afterwards; SrcData reads 0x0F0F with SrcRdy=0 in the next cycle.
  - With r9 busy, Reserve r9 alone. Required: ResConflict=1.
- **Parameter sweep.** Run with WIDTH=32, DEPTH=8, ZERO_REG=0.
  - Required: a write of r0=0xDEADBEEF reads back.
  - Required: Reserve r0 clears SrcRdy1(r0).
  - Required: a write to r7 does not alias into any other register.
